// File: rtl/game_pkg.sv
// Shared definitions for the memory game: FSM states, LFSR geometry and LED decode.
// Both the playback side and the switch-side game FSM import this package.
package game_pkg;

  typedef enum logic [2:0] {IDLE, FILL, GAP, ON, DONE} state_e;

  localparam int LFSR_W = 8;
  // Feedback taps on bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 8'h01;

  localparam int STEP_W = 2;
  localparam int LED_W  = 4;
  localparam int IDX_W  = 4;

  function automatic logic [LED_W-1:0] step_onehot(input logic [STEP_W-1:0] step);
    step_onehot = LED_W'(1) << step;
  endfunction

endpackage

// File: rtl/led_sequence_player_if.sv
// Control, read-back and LED bundle between the game FSM (master) and the player (slave).
interface led_sequence_player_if;
  import game_pkg::*;

  logic              i_seed_load;
  logic [LFSR_W-1:0] i_seed;
  logic              i_play;
  logic [IDX_W-1:0]  i_len;
  logic [IDX_W-1:0]  i_rd_idx;
  logic [STEP_W-1:0] o_rd_step;
  logic [LED_W-1:0]  o_led;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_seed_load, i_seed, i_play, i_len, i_rd_idx,
    input  o_rd_step, o_led, o_busy, o_done
  );

  modport slave (
    input  i_seed_load, i_seed, i_play, i_len, i_rd_idx,
    output o_rd_step, o_led, o_busy, o_done
  );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and step enable; exposes the low bits of the next state.
module lfsr8
  import game_pkg::*;
#(
  parameter int OUT_W = LFSR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_en,
  output logic [OUT_W-1:0]  o_next
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign o_next   = lfsr_nxt[OUT_W-1:0];

  // An all-zero seed would lock the register, so it is promoted to the init value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else if (i_load) begin
      lfsr_q <= (i_seed == '0) ? LFSR_INIT : i_seed;
    end else if (i_en) begin
      lfsr_q <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/led_sequence_player.sv
// Fills the pseudo-random target sequence and flashes its first len steps on the LEDs,
// each step preceded by a dark gap.
module led_sequence_player
  import game_pkg::*;
#(
  parameter int CLK_PER_SEC = 6,
  parameter int ON_CYCLES   = CLK_PER_SEC,
  parameter int OFF_CYCLES  = CLK_PER_SEC / 2,
  parameter int GAME_LIMIT  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  led_sequence_player_if.slave  bus
);

  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_nxt;
  logic [IDX_W-1:0]  k_q, k_nxt;
  logic [IDX_W-1:0]  len_q, len_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [LED_W-1:0]  led_q, led_nxt;
  logic [STEP_W-1:0] seq_q [GAME_LIMIT];
  logic [STEP_W-1:0] fill_step;
  logic [STEP_W-1:0] step_at_k_nxt;
  logic [STEP_W-1:0] rd_step;
  logic              seed_accept;
  logic              fill_en;
  logic [IDX_W-1:0]  play_len;

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len);
    clamp_len = (len > IDX_W'(GAME_LIMIT)) ? IDX_W'(GAME_LIMIT) : len;
  endfunction

  assign seed_accept = (state_q == IDLE) && bus.i_seed_load;
  assign fill_en     = (state_q == FILL);
  assign play_len    = clamp_len(bus.i_len);

  lfsr8 #(
    .OUT_W (STEP_W)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (seed_accept),
    .i_seed  (bus.i_seed),
    .i_en    (fill_en),
    .o_next  (fill_step)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
      len_q   <= len_nxt;
      cnt_q   <= cnt_nxt;
      led_q   <= led_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < GAME_LIMIT; i++) seq_q[i] <= '0;
    end else if (fill_en) begin
      for (int i = 0; i < GAME_LIMIT; i++) begin
        if (k_q == IDX_W'(i)) seq_q[i] <= fill_step;
      end
    end
  end

  // Seed load has priority over play; both are ignored outside IDLE
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_seed_load) begin
          state_nxt = FILL;
          k_nxt     = '0;
        end else if (bus.i_play) begin
          len_nxt   = play_len;
          k_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = (play_len == '0) ? DONE : GAP;
        end
      end
      FILL: begin
        k_nxt = k_q + IDX_W'(1);
        if (k_q == IDX_W'(GAME_LIMIT - 1)) state_nxt = DONE;
      end
      GAP: begin
        if (cnt_q == CNT_W'(OFF_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ON;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ON: begin
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          cnt_nxt   = '0;
          k_nxt     = k_q + IDX_W'(1);
          state_nxt = ((k_q + IDX_W'(1)) == len_q) ? DONE : GAP;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The LED register is loaded from the upcoming state so it lights on the edge entering ON
  always_comb begin
    step_at_k_nxt = '0;
    for (int i = 0; i < GAME_LIMIT; i++) begin
      if (k_nxt == IDX_W'(i)) step_at_k_nxt = seq_q[i];
    end
    led_nxt    = (state_nxt == ON) ? step_onehot(step_at_k_nxt) : '0;
    bus.o_busy = (state_q == FILL) || (state_q == GAP) || (state_q == ON);
    bus.o_done = (state_q == DONE);
  end

  always_comb begin
    rd_step = '0;
    for (int i = 0; i < GAME_LIMIT; i++) begin
      if (bus.i_rd_idx == IDX_W'(i)) rd_step = seq_q[i];
    end
  end

  assign bus.o_rd_step = rd_step;
  assign bus.o_led     = led_q;

endmodule

// File: tb/tb_led_sequence_player.sv
// Directed bench for led_sequence_player: fill, playback traces, length clamping,
// input priority/ignoring and asynchronous reset mid-playback.
module tb_led_sequence_player;
  import game_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Sequence produced from seed 8'h01: lfsr 02,04,08,11,23,47,8E,1C
  logic [1:0] exp_seq [8] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0};

  led_sequence_player_if bus ();

  led_sequence_player #(
    .CLK_PER_SEC (6),
    .GAME_LIMIT  (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_busy(output int n, output int lit);
    n   = 0;
    lit = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      if (bus.o_led != 4'd0) lit++;
      step();
    end
  endtask

  task automatic check_seq(input string tag, input bit zeros);
    for (int i = 0; i < 8; i++) begin
      bus.i_rd_idx = 4'(i);
      #1;
      chk($sformatf("%s_seq%0d", tag, i), 32'(bus.o_rd_step), zeros ? 32'd0 : 32'(exp_seq[i]));
    end
  endtask

  initial begin
    int         n;
    int         lit;
    logic [3:0] e;

    bus.i_seed_load = 1'b0;
    bus.i_seed      = 8'h00;
    bus.i_play      = 1'b0;
    bus.i_len       = 4'd0;
    bus.i_rd_idx    = 4'd0;
    step();
    step();
    chk("reset_state", {bus.o_busy, bus.o_done, bus.o_led}, 6'b0);
    check_seq("reset", 1'b1);
    rst_n = 1'b1;
    step();

    // Fill from seed 8'h01
    bus.i_seed      = 8'h01;
    bus.i_seed_load = 1'b1;
    step();
    bus.i_seed_load = 1'b0;
    run_busy(n, lit);
    chk("fill_cycles", n, 8);
    chk("fill_lit", lit, 0);
    chk("fill_done", {bus.o_busy, bus.o_done, bus.o_led}, 6'b010000);
    step();
    chk("fill_done_pulse", bus.o_done, 0);
    check_seq("fill", 1'b0);
    bus.i_rd_idx = 4'd8;
    #1;
    chk("rd_oob8", bus.o_rd_step, 0);
    bus.i_rd_idx = 4'd9;
    #1;
    chk("rd_oob9", bus.o_rd_step, 0);

    // Play three steps; a play and a seed load issued mid-playback must be ignored
    bus.i_play = 1'b1;
    bus.i_len  = 4'd3;
    step();
    bus.i_play = 1'b0;
    bus.i_len  = 4'd0;
    for (int i = 0; i < 27; i++) begin
      e = ((i % 9) < 3) ? 4'b0000 : (4'b0001 << exp_seq[i / 9]);
      chk($sformatf("play3_c%0d", i), {bus.o_busy, bus.o_led}, {1'b1, e});
      if (i == 10) begin
        bus.i_play = 1'b1;
        bus.i_len  = 4'd1;
      end
      if (i == 20) begin
        bus.i_seed_load = 1'b1;
        bus.i_seed      = 8'h55;
      end
      step();
      bus.i_play      = 1'b0;
      bus.i_seed_load = 1'b0;
    end
    chk("play3_done", {bus.o_busy, bus.o_done, bus.o_led}, 6'b010000);
    step();
    chk("play3_idle", {bus.o_busy, bus.o_done, bus.o_led}, 6'b0);
    check_seq("after_play", 1'b0);

    // Zero length finishes immediately
    bus.i_play = 1'b1;
    bus.i_len  = 4'd0;
    step();
    bus.i_play = 1'b0;
    chk("len0_done", {bus.o_busy, bus.o_done, bus.o_led}, 6'b010000);
    step();
    chk("len0_idle", {bus.o_busy, bus.o_done, bus.o_led}, 6'b0);

    // Length 15 is clamped to 8 steps
    bus.i_play = 1'b1;
    bus.i_len  = 4'd15;
    step();
    bus.i_play = 1'b0;
    run_busy(n, lit);
    chk("clamp_busy", n, 72);
    chk("clamp_lit", lit, 48);
    chk("clamp_done", bus.o_done, 1);
    step();

    // Reseed with another value, then seed 8'h00 together with play
    bus.i_seed      = 8'hA5;
    bus.i_seed_load = 1'b1;
    step();
    bus.i_seed_load = 1'b0;
    run_busy(n, lit);
    step();
    bus.i_seed      = 8'h00;
    bus.i_seed_load = 1'b1;
    bus.i_play      = 1'b1;
    bus.i_len       = 4'd3;
    step();
    bus.i_seed_load = 1'b0;
    bus.i_play      = 1'b0;
    run_busy(n, lit);
    chk("both_busy", n, 8);
    chk("both_lit", lit, 0);
    chk("both_done", bus.o_done, 1);
    step();
    step();
    chk("both_no_play", {bus.o_busy, bus.o_led}, 5'b0);
    check_seq("seed00", 1'b0);

    // Asynchronous reset during the lit phase of step 2
    bus.i_play = 1'b1;
    bus.i_len  = 4'd3;
    step();
    bus.i_play = 1'b0;
    repeat (13) step();
    chk("pre_rst", {bus.o_busy, bus.o_led}, 5'b10001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.o_busy, bus.o_done, bus.o_led}, 6'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", {bus.o_busy, bus.o_done, bus.o_led}, 6'b0);
    check_seq("post_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequence_player.md
Name: led_sequence_player

Overview:
- Playback side of the memory game. It generates and stores the pseudo-random target sequence, then flashes it on the four LEDs one step at a time.
- The switch-side game FSM consumes it. The FSM starts playback, waits for done, then uses the combinational read port to check each player switch press against the stored step.
- Timing is expressed in CLK_PER_SEC units, so the simulation clock can be tiny.

Parameters:
- CLK_PER_SEC, 6, clock cycles per second.
- ON_CYCLES, CLK_PER_SEC, cycles each step's LED is lit.
- OFF_CYCLES, CLK_PER_SEC/2, dark gap before each step (must be ≥1).
- GAME_LIMIT, 8, maximum sequence length (1..15).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_seed_load  in  1  pulse: reseed LFSR and refill sequence.
- i_seed  in  8  LFSR seed; 8'h00 is replaced by 8'h01.
- i_play  in  1  pulse: play the first i_len steps.
- i_len  in  4  steps to play, sampled with i_play.
- i_rd_idx  in  4  read index into the stored sequence.
- o_rd_step  out  2  seq[i_rd_idx], combinational; 0 if i_rd_idx ≥ GAME_LIMIT.
- o_led  out  4  one-hot LED of the current step, registered.
- o_busy  out  1  high in FILL, GAP, ON.
- o_done  out  1  one-cycle pulse at end of fill or playback.

Behaviour:
- Reset (async, any state):
  - state=IDLE, lfsr=8'h01, seq[*]=0.
  - step/count counters=0.
  - o_led=0, o_busy=0, o_done=0.
- LFSR:
  - fb = l[7]^l[5]^l[4]^l[3].
  - next = {l[6:0], fb}.
  - Advances only in FILL.
- FSM states: IDLE, FILL, GAP, ON, DONE.
- IDLE:
  - i_seed_load → lfsr<=(i_seed==0 ? 8'h01 : i_seed), k<=0, go FILL.
  - else i_play → latch len=min(i_len, GAME_LIMIT), k<=0.
    - len==0: go DONE (no LED activity).
    - otherwise: go GAP.
  - Both pulses in the same cycle: seed_load wins and i_play is dropped.
- FILL: one step per cycle.
  - lfsr<=next, seq[k]<=next[1:0], k++.
  - After k=GAME_LIMIT-1 is written → DONE.
  - Duration is exactly GAME_LIMIT cycles.
- GAP:
  - o_led=0 for OFF_CYCLES cycles, then → ON.
- ON:
  - o_led=4'b0001<<seq[k] for ON_CYCLES cycles.
  - Then k++: if k==len → DONE, else → GAP.
- DONE:
  - o_done=1 for one cycle, o_busy=0, o_led=0 → IDLE.
- Latency:
  - i_play sampled high at edge n → GAP from n+1.
  - First LED lit from edge n+1+OFF_CYCLES.
  - Total playback = len*(OFF_CYCLES+ON_CYCLES) cycles, then o_done.
- While o_busy: i_play and i_seed_load are ignored (not queued). i_len is sampled only at accept.
- seq is unchanged by playback. Repeated i_play with an increasing len replays the same prefix (round growth).
- o_rd_step is valid at all times. During FILL it may show partially updated contents.
- Counters are sized $clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits; no wrap in normal operation.

Decomposition:
- Package game_pkg:
  - state enum (IDLE, FILL, GAP, ON, DONE).
  - LFSR width (8) and taps.
  - STEP_W=2, LED_W=4.
  - one-hot decode function.
  - Shared with the switch-side game FSM.
- Sub-module lfsr8:
  - seed load, enable, next-state output.
  - Reused by the game for any other randomness.

Test Plan:
- Reset then seed 8'h01, GAME_LIMIT=8 → o_busy high exactly 8 cycles, then o_done pulse. o_rd_step for idx 0..4 = 2,0,0,1,3.
- i_play, i_len=3, CLK_PER_SEC=6 (ON=6, OFF=3) → o_led sequence: 0×3, 4'b0100×6, 0×3, 4'b0001×6, 0×3, 4'b0001×6, then o_done one cycle. Total 27 busy cycles.
- i_len=0 → o_done the next cycle, o_led stays 0. i_len=15 → clamped to 8 steps.
- i_seed_load and i_play in the same cycle → fill only, no LEDs. i_play pulsed mid-playback → ignored, step count unchanged.
- i_seed=8'h00 → identical sequence to seed 8'h01. i_rd_idx=9 → o_rd_step=0.
- Assert i_rst_n=0 during the ON state of step 2 → o_led=0 and o_busy=0 immediately (asynchronously). After release, seq reads all 0 and the FSM is in IDLE.
